// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if: requester-side and stack32-side signals of the operand stack arbiter
interface stack_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int GW    = NREQ > 1 ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_trigger;
  logic [NREQ-1:0]       req_push;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_done;
  logic [WIDTH-1:0]      req_rdata;
  logic                  req_err;
  logic                  stk_trigger;
  logic                  stk_push;
  logic [WIDTH-1:0]      stk_wdata;
  logic [WIDTH-1:0]      stk_rdata;
  logic                  stk_done;
  logic                  busy;
  logic [GW-1:0]         grant_id;
  logic                  collision;
  modport master (
    output req_trigger, req_push, req_wdata, stk_rdata, stk_done,
    input  req_done, req_rdata, req_err, stk_trigger, stk_push, stk_wdata, busy, grant_id, collision
  );
  modport slave (
    input  req_trigger, req_push, req_wdata, stk_rdata, stk_done,
    output req_done, req_rdata, req_err, stk_trigger, stk_push, stk_wdata, busy, grant_id, collision
  );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one stack32 among NREQ requesters; optional WAIT watchdog via STACK_ARB_TIMEOUT_EN
module stack_arbiter #(
  parameter int NREQ           = 2,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  stack_arbiter_if.slave bus
);
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state;
  logic [NREQ-1:0]  pending;
  logic [NREQ-1:0]  op_push;
  logic [WIDTH-1:0] op_data [NREQ];
  logic [GW-1:0]    rr;
  logic [GW-1:0]    pick;
  logic [GW-1:0]    nxt_rr;
  logic             found;
  logic             tmo_hit;
  logic             fin;
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("stack_arbiter: unsupported parameter set");
  end
  assign fin    = state == WAIT && (bus.stk_done || tmo_hit);
  assign nxt_rr = GW'((int'(bus.grant_id) + 1) % NREQ);
`ifdef STACK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  assign tmo_hit = tmo_cnt == CW'(TIMEOUT_CYCLES - 1);
  // count consecutive WAIT cycles; restarts on every new operation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_cnt <= '0;
    else tmo_cnt <= state == WAIT ? tmo_cnt + 1'b1 : '0;
`else
  assign tmo_hit = 1'b0;
`endif
  // first pending requester at or after the round-robin pointer, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && pending[(int'(rr) + k) % NREQ]) begin
        pick  = GW'((int'(rr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  // capture trigger pulses; a retrigger while still pending is dropped and flagged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending       <= '0;
      op_push       <= '0;
      bus.collision <= 1'b0;
      for (int k = 0; k < NREQ; k++) op_data[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (fin && bus.grant_id == GW'(k)) pending[k] <= 1'b0;
        if (bus.req_trigger[k]) begin
          if (pending[k]) bus.collision <= 1'b1;
          else begin
            pending[k] <= 1'b1;
            op_push[k] <= bus.req_push[k];
            op_data[k] <= bus.req_wdata[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  // one stack operation at a time: grant, pulse the stack, wait, answer the owner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      rr              <= '0;
      bus.grant_id    <= '0;
      bus.stk_trigger <= 1'b0;
      bus.stk_push    <= 1'b0;
      bus.stk_wdata   <= '0;
      bus.req_done    <= '0;
      bus.req_rdata   <= '0;
      bus.req_err     <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.stk_trigger <= 1'b0;
      bus.req_done    <= '0;
      case (state)
        IDLE: if (found) begin
          state           <= ISSUE;
          bus.grant_id    <= pick;
          bus.stk_push    <= op_push[pick];
          bus.stk_wdata   <= op_data[pick];
          bus.stk_trigger <= 1'b1;
          bus.busy        <= 1'b1;
        end
        ISSUE: state <= WAIT;
        WAIT: if (fin) begin
          state         <= RESP;
          bus.busy      <= 1'b0;
          bus.req_done  <= NREQ'(1) << bus.grant_id;
          bus.req_err   <= !bus.stk_done;
          bus.req_rdata <= bus.stk_done ? bus.stk_rdata : '0;
        end
        RESP: begin
          state <= IDLE;
          rr    <= nxt_rr;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed vector bench for stack_arbiter with a behavioural stack32
module tb_stack_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  int tests = 0;
  int fails = 0;
  int ndone = 0;
  int ntrig = 0;
  int cnt, sp;
  logic [31:0] mem [64];
  stack_arbiter_if #(.NREQ(2), .WIDTH(32)) bus ();
  stack_arbiter #(.NREQ(2), .WIDTH(32), .TIMEOUT_CYCLES(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  // behavioural stack: done LAT cycles after the trigger, stalled while hold is high
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 0;
      sp <= 0;
      bus.stk_done <= 1'b0;
      bus.stk_rdata <= '0;
    end else begin
      bus.stk_done <= 1'b0;
      if (bus.stk_trigger) cnt <= LAT;
      else if (cnt > 0 && !hold) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          bus.stk_done <= 1'b1;
          if (bus.stk_push) begin
            mem[sp] <= bus.stk_wdata;
            sp <= sp + 1;
          end else begin
            bus.stk_rdata <= mem[sp-1];
            sp <= sp - 1;
          end
        end
      end
    end
  always @(negedge clk) begin
    if (|bus.req_done) ndone++;
    if (bus.stk_trigger) ntrig++;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  typedef struct {
    logic [1:0]  req;
    logic        push;
    logic [31:0] data;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t v [6];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic trig(input logic [1:0] m, input logic [1:0] p, input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    bus.req_trigger = m;
    bus.req_push = p;
    bus.req_wdata = {d1, d0};
    @(negedge clk);
    bus.req_trigger = '0;
  endtask
  task automatic wait_trig(output logic p, output logic [31:0] d);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.stk_trigger) break;
    end
    if (!bus.stk_trigger) check("stk_trigger_wait", {31'b0, bus.stk_trigger}, 32'd1);
    p = bus.stk_push;
    d = bus.stk_wdata;
  endtask
  task automatic wait_done(output logic [1:0] d, output logic [31:0] rd, output logic gid,
                           output logic err, output logic prev_sd, output int wc);
    prev_sd = 1'b0;
    wc = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (|bus.req_done) break;
      prev_sd = bus.stk_done;
      if (bus.busy && !bus.stk_trigger) wc++;
    end
    if (!(|bus.req_done)) check("req_done_wait", {30'b0, bus.req_done}, 32'd1);
    d = bus.req_done;
    rd = bus.req_rdata;
    gid = bus.grant_id;
    err = bus.req_err;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic p, gid, err, psd;
    logic [1:0] d;
    logic [31:0] wd, rd;
    int wc, base_t, base_d;
    bus.req_trigger = '0;
    bus.req_push = '0;
    bus.req_wdata = '0;
    v[0] = '{2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0};
    v[1] = '{2'b01, 1'b1, 32'h0000_0002, 32'h0};
    v[2] = '{2'b10, 1'b0, 32'h0, 32'h0000_0002};
    v[3] = '{2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF};
    v[4] = '{2'b10, 1'b1, 32'hA5A5_A5A5, 32'h0};
    v[5] = '{2'b01, 1'b0, 32'h0, 32'hA5A5_A5A5};
    #1;
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_req_done", {30'b0, bus.req_done}, 0);
    check("rst_stk_trigger", {31'b0, bus.stk_trigger}, 0);
    check("rst_grant_id", {31'b0, bus.grant_id}, 0);
    check("rst_collision", {31'b0, bus.collision}, 0);
    check("rst_req_rdata", bus.req_rdata, 0);
    check("rst_req_err", {31'b0, bus.req_err}, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      trig(v[i].req, {2{v[i].push}}, v[i].data, v[i].data);
      wait_trig(p, wd);
      check($sformatf("v%0d_stk_push", i), {31'b0, p}, {31'b0, v[i].push});
      if (v[i].push) check($sformatf("v%0d_stk_wdata", i), wd, v[i].data);
      wait_done(d, rd, gid, err, psd, wc);
      check($sformatf("v%0d_req_done", i), {30'b0, d}, {30'b0, v[i].req});
      check($sformatf("v%0d_grant_id", i), {31'b0, gid}, {31'b0, v[i].req[1]});
      check($sformatf("v%0d_req_err", i), {31'b0, err}, 0);
      check($sformatf("v%0d_done_after_stk_done", i), {31'b0, psd}, 1);
      if (!v[i].push) check($sformatf("v%0d_req_rdata", i), rd, v[i].exp_rdata);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), {30'b0, bus.req_done}, 0);
    end
    do_reset();
    trig(2'b11, 2'b11, 32'd5, 32'd7);
    wait_trig(p, wd);
    check("sim_first_wdata", wd, 32'd5);
    wait_done(d, rd, gid, err, psd, wc);
    check("sim_first_done", {30'b0, d}, 32'b01);
    wait_trig(p, wd);
    check("sim_second_wdata", wd, 32'd7);
    wait_done(d, rd, gid, err, psd, wc);
    check("sim_second_done", {30'b0, d}, 32'b10);
    check("sim_second_grant", {31'b0, gid}, 1);
    trig(2'b01, 2'b00, 0, 0);
    wait_done(d, rd, gid, err, psd, wc);
    check("sim_pop1", rd, 32'd7);
    trig(2'b01, 2'b00, 0, 0);
    wait_done(d, rd, gid, err, psd, wc);
    check("sim_pop2", rd, 32'd5);
    do_reset();
    trig(2'b11, 2'b11, 32'h10, 32'h20);
    for (int g = 0; g < 8; g++) begin
      wait_done(d, rd, gid, err, psd, wc);
      check($sformatf("rr_grant%0d", g), {31'b0, gid}, g % 2);
      if (g < 6) begin
        bus.req_trigger = d;
        bus.req_push = 2'b11;
        @(negedge clk);
        bus.req_trigger = '0;
      end
    end
    do_reset();
    base_t = ntrig;
    hold = 1'b1;
    trig(2'b01, 2'b01, 32'h11, 0);
    repeat (3) @(negedge clk);
    trig(2'b10, 2'b10, 0, 32'h22);
    trig(2'b10, 2'b10, 0, 32'h33);
    check("col_flag", {31'b0, bus.collision}, 1);
    hold = 1'b0;
    wait_done(d, rd, gid, err, psd, wc);
    check("col_done0", {30'b0, d}, 32'b01);
    wait_trig(p, wd);
    check("col_r1_data", wd, 32'h22);
    wait_done(d, rd, gid, err, psd, wc);
    check("col_done1", {30'b0, d}, 32'b10);
    repeat (20) @(negedge clk);
    check("col_op_count", ntrig - base_t, 2);
    trig(2'b01, 2'b00, 0, 0);
    wait_done(d, rd, gid, err, psd, wc);
    check("col_pop1", rd, 32'h22);
    trig(2'b01, 2'b00, 0, 0);
    wait_done(d, rd, gid, err, psd, wc);
    check("col_pop2", rd, 32'h11);
    check("col_sticky", {31'b0, bus.collision}, 1);
    do_reset();
    hold = 1'b1;
    trig(2'b01, 2'b01, 32'hDEAD_BEEF, 0);
    repeat (3) @(negedge clk);
    check("rw_busy_before", {31'b0, bus.busy}, 1);
    base_t = ntrig;
    base_d = ndone;
    rst_n = 1'b0;
    #1;
    check("rw_busy", {31'b0, bus.busy}, 0);
    check("rw_stk_push", {31'b0, bus.stk_push}, 0);
    check("rw_stk_wdata", bus.stk_wdata, 0);
    check("rw_req_done", {30'b0, bus.req_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    repeat (20) @(negedge clk);
    check("rw_no_done", ndone - base_d, 0);
    check("rw_no_reissue", ntrig - base_t, 0);
`ifdef STACK_ARB_TIMEOUT_EN
    do_reset();
    hold = 1'b1;
    trig(2'b10, 2'b10, 0, 32'h77);
    wait_done(d, rd, gid, err, psd, wc);
    check("tmo_done", {30'b0, d}, 32'b10);
    check("tmo_err", {31'b0, err}, 1);
    check("tmo_rdata", rd, 0);
    check("tmo_wait_cycles", wc, 64);
    hold = 1'b0;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Shares the single 32-bit operand stack (push/trigger/done handshake) between NREQ requesters, e.g. the bytecode control unit and the local-variable/invoke unit. Captures one-cycle trigger pulses and grants round-robin. Issues exactly one stack operation at a time and routes the completion and pop data back to the owner. Sits between the requesters and stack32; the stack itself is unchanged.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, 32, stack data width
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_trigger  in  NREQ  per-requester one-cycle operation request pulse
req_push  in  NREQ  per-requester op type, sampled with trigger: 1=push, 0=pop
req_wdata  in  NREQ*WIDTH  push data; slice i belongs to requester i, sampled with trigger
req_done  out  NREQ  one-cycle completion pulse to the owning requester
req_rdata  out  WIDTH  pop data, valid while the owner's req_done is high
req_err  out  1  completion was a watchdog abort; valid with req_done
stk_trigger  out  1  one-cycle operation pulse to stack32
stk_push  out  1  op type to stack32, held from issue until done
stk_wdata  out  WIDTH  push data to stack32, held from issue until done
stk_rdata  in  WIDTH  stack32 read_value
stk_done  in  1  stack32 done_out
busy  out  1  high in ISSUE or WAIT
grant_id  out  max(1,$clog2(NREQ))  index of current or last owner
collision  out  1  sticky; a trigger arrived while that requester already had a request pending

Behaviour:
- Reset, asynchronous: all outputs 0; pending, captured op and data cleared; RR pointer = 0; FSM = IDLE. Reset mid-operation abandons the stack op; the requester gets no done.
- Capture: on req_trigger[i], set pending[i] and latch push/wdata slice i.
  - If pending[i] is already set: new request dropped, original kept, collision set.
  - A trigger in the same cycle as req_done[i] is accepted as a new pending request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any pending, pick the first pending index at or after the RR pointer (wrapping). Load stk_push/stk_wdata, set grant_id, go to ISSUE. A request captured in cycle T is arbitrated from cycle T+1.
  - ISSUE: stk_trigger=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold stk_push/stk_wdata. On stk_done: register stk_rdata into req_rdata, clear pending[owner], go to RESP.
  - RESP: req_done[owner]=1 for one cycle. RR pointer = owner+1 mod NREQ. Go to IDLE.
- Stack done in the same cycle as stk_trigger is impossible with stack32 and is ignored.
- stk_done outside WAIT is ignored.
- Minimum turnaround: trigger to req_done = 4 cycles + stack latency. Back-to-back grants have one IDLE cycle between them.
- req_rdata holds its last value until the next completion. Its value on push completions is don't-care.
- Fairness: with all NREQ requesters continuously pending, each is served once per NREQ grants.

Optional Feature:
STACK_ARB_TIMEOUT_EN
- Defined: a counter runs in WAIT. After TIMEOUT_CYCLES without stk_done, go to RESP with req_err=1 and req_rdata=0. Pending is cleared and the RR pointer advances normally.
- Not defined: no counter is built, req_err is tied 0, and WAIT waits indefinitely.

Test Plan:
- Single push: req0 trigger push 0xFFFFFFFF -> one stk_trigger with stk_push=1, stk_wdata=0xFFFFFFFF; req_done[0] pulse one cycle after stk_done; req_done[1] never set.
- Pop routing: req0 pushes 2, then req1 pops -> req_done[1] pulses with req_rdata=0x00000002; grant_id=1.
- Simultaneous triggers after reset: req0 pushes 5, req1 pushes 7 in the same cycle -> req0 served first, then req1; a following pop returns 7 and the next pop returns 5.
- Round-robin: both requesters re-trigger on every done for 8 grants -> grant_id sequence 0,1,0,1,0,1,0,1.
- Collision: req1 triggers twice while req0's op is in WAIT -> collision=1; only one op executes for req1, using its first data value.
- Reset in WAIT: drop rst_n while WAIT -> all outputs 0 immediately; after release no req_done occurs. With STACK_ARB_TIMEOUT_EN and stk_done held low: req_done with req_err=1 after 64 WAIT cycles.
